// File: rtl/stk_pipe_wrbk.sv
// -----------------------------------------------------------------------------
// stk_pipe_wrbk
// Writeback stage of the stack pipeline. It takes WRBK microcode from the MEM
// stage, holds it for one cycle in a stage register, and then commits the
// head/tail pointer updates into a per-engine context table. Each committed op
// pushes a completion response into a small skid FIFO that is drained over a
// valid/ready handshake. A combinational read port returns the context of one
// engine and forwards any pending stage update, so the lookup stage never sees
// stale data.
//
// Ports
//   clk, rst_n                  clock; synchronous active-low reset
//   i_wrbk_uc_vld               microcode valid from MEM stage
//   i_wrbk_uc_engid             target engine of the microcode
//   i_wrbk_uc_head_vld/_ptr     head pointer update (enable / value)
//   i_wrbk_uc_tail_vld/_ptr     tail pointer update (enable / value)
//   o_wrbk_stall                upstream must hold the microcode while high
//   i_rd_engid                  context read address (lookup stage)
//   o_rd_empty/_head_ptr/_tail_ptr  context of i_rd_engid, bypassed
//   o_rsp_vld, i_rsp_rdy        response handshake
//   o_rsp_engid/_head_ptr/_empty    response payload (post-update values)
// -----------------------------------------------------------------------------
module stk_pipe_wrbk #(
    parameter int ENGS_N = 4,
    parameter int PTR_W  = 8,
    parameter int SKID_N = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_wrbk_uc_vld,
    input  logic [((ENGS_N > 1) ? $clog2(ENGS_N) : 1)-1:0] i_wrbk_uc_engid,
    input  logic                                   i_wrbk_uc_head_vld,
    input  logic [PTR_W-1:0]                       i_wrbk_uc_head_ptr,
    input  logic                                   i_wrbk_uc_tail_vld,
    input  logic [PTR_W-1:0]                       i_wrbk_uc_tail_ptr,
    output logic                                   o_wrbk_stall,
    input  logic [((ENGS_N > 1) ? $clog2(ENGS_N) : 1)-1:0] i_rd_engid,
    output logic                                   o_rd_empty,
    output logic [PTR_W-1:0]                       o_rd_head_ptr,
    output logic [PTR_W-1:0]                       o_rd_tail_ptr,
    output logic                                   o_rsp_vld,
    input  logic                                   i_rsp_rdy,
    output logic [((ENGS_N > 1) ? $clog2(ENGS_N) : 1)-1:0] o_rsp_engid,
    output logic [PTR_W-1:0]                       o_rsp_head_ptr,
    output logic                                   o_rsp_empty
);

    localparam int ENG_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;
    localparam int SKP_W = (SKID_N > 1) ? $clog2(SKID_N) : 1;
    localparam int CNT_W = $clog2(SKID_N + 1);
    localparam logic [PTR_W-1:0] NULL_PTR = '1;

    // Context table
    logic             r_empty [ENGS_N];
    logic [PTR_W-1:0] r_head  [ENGS_N];
    logic [PTR_W-1:0] r_tail  [ENGS_N];

    // Stage register
    logic             r_stg_vld;
    logic [ENG_W-1:0] r_stg_engid;
    logic             r_stg_head_vld;
    logic [PTR_W-1:0] r_stg_head_ptr;
    logic             r_stg_tail_vld;
    logic [PTR_W-1:0] r_stg_tail_ptr;

    // Response FIFO
    logic [ENG_W-1:0] r_fifo_eng   [SKID_N];
    logic [PTR_W-1:0] r_fifo_head  [SKID_N];
    logic             r_fifo_empty [SKID_N];
    logic [SKP_W-1:0] r_wr_ptr;
    logic [SKP_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W:0]   w_occ;
    logic [PTR_W-1:0] w_new_head;
    logic             w_new_empty;

    function automatic logic [SKP_W-1:0] ptrInc(input logic [SKP_W-1:0] p);
        return (p == SKP_W'(SKID_N - 1)) ? '0 : p + 1'b1;
    endfunction

    // The stage op counts as occupancy because it will push on the next edge
    // regardless of what the consumer does; this is what makes overflow impossible.
    assign w_occ        = {1'b0, r_count} + {{CNT_W{1'b0}}, r_stg_vld};
    assign o_wrbk_stall = (w_occ >= (CNT_W + 1)'(SKID_N));
    assign w_accept     = i_wrbk_uc_vld & ~o_wrbk_stall;
    assign w_push       = r_stg_vld;
    assign o_rsp_vld    = (r_count != '0);
    assign w_pop        = o_rsp_vld & i_rsp_rdy;

    // A head update defines the new empty flag; without one the entry keeps its old values.
    assign w_new_head  = r_stg_head_vld ? r_stg_head_ptr : r_head[r_stg_engid];
    assign w_new_empty = r_stg_head_vld ? (r_stg_head_ptr == NULL_PTR) : r_empty[r_stg_engid];

    assign o_rsp_engid    = r_fifo_eng[r_rd_ptr];
    assign o_rsp_head_ptr = r_fifo_head[r_rd_ptr];
    assign o_rsp_empty    = r_fifo_empty[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stg_vld      <= 1'b0;
            r_stg_engid    <= '0;
            r_stg_head_vld <= 1'b0;
            r_stg_head_ptr <= '0;
            r_stg_tail_vld <= 1'b0;
            r_stg_tail_ptr <= '0;
        end else begin
            r_stg_vld <= w_accept;
            if (w_accept) begin
                r_stg_engid    <= i_wrbk_uc_engid;
                r_stg_head_vld <= i_wrbk_uc_head_vld;
                r_stg_head_ptr <= i_wrbk_uc_head_ptr;
                r_stg_tail_vld <= i_wrbk_uc_tail_vld;
                r_stg_tail_ptr <= i_wrbk_uc_tail_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < ENGS_N; e++) begin
                r_empty[e] <= 1'b1;
                r_head[e]  <= '0;
                r_tail[e]  <= '0;
            end
        end else if (r_stg_vld) begin
            if (r_stg_head_vld) begin
                r_head[r_stg_engid]  <= r_stg_head_ptr;
                r_empty[r_stg_engid] <= (r_stg_head_ptr == NULL_PTR);
            end
            if (r_stg_tail_vld) begin
                r_tail[r_stg_engid] <= r_stg_tail_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptrInc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptrInc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only observed while the count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_eng[r_wr_ptr]   <= r_stg_engid;
            r_fifo_head[r_wr_ptr]  <= w_new_head;
            r_fifo_empty[r_wr_ptr] <= w_new_empty;
        end
    end

    // Pending stage fields win over the table, each under its own enable.
    always_comb begin
        o_rd_empty    = r_empty[i_rd_engid];
        o_rd_head_ptr = r_head[i_rd_engid];
        o_rd_tail_ptr = r_tail[i_rd_engid];
        if (r_stg_vld && (r_stg_engid == i_rd_engid)) begin
            if (r_stg_head_vld) begin
                o_rd_head_ptr = r_stg_head_ptr;
                o_rd_empty    = (r_stg_head_ptr == NULL_PTR);
            end
            if (r_stg_tail_vld) begin
                o_rd_tail_ptr = r_stg_tail_ptr;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == CNT_W'(SKID_N))));

endmodule
